// File: rtl/fifo_wr_arbiter_if.sv
// Shared FIFO write-port bundle between the requesters, the arbiter and the FIFO.
// The master view belongs to the arbiter; the slave view belongs to the requesters/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int data_width = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*data_width-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            gnt;
  logic                          w_en;
  logic [data_width-1:0]         data_in;
  logic                          full;
  logic [15:0]                   stall_cnt;

  modport master (
    input  req, req_data, req_last, full,
    output ack, gnt, w_en, data_in, stall_cnt
  );

  modport slave (
    output req, req_data, req_last, full,
    input  ack, gnt, w_en, data_in, stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that shares one FIFO write port among NUM_REQ requesters.
// Writes are back-pressured combinationally by full, so the FIFO never sees a write while full.
module fifo_wr_arbiter #(
  parameter int data_width = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic               w_clk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.master  bus
);
  localparam int CUR_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [CUR_W-1:0]       cur_q;
  logic [CUR_W-1:0]       rr_ptr_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [15:0]            stall_cnt_q;

  logic [CUR_W-1:0]       pick_d;
  logic                   pick_vld_d;
  logic [CUR_W-1:0]       next_ptr_d;
  logic                   owner_req;
  logic                   wr;
  logic                   last_hit;

  // Scan downward so the requester closest above rr_ptr_q is the one left in pick_d.
  always_comb begin
    pick_d     = rr_ptr_q;
    pick_vld_d = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_d     = CUR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        pick_vld_d = 1'b1;
      end
    end
  end

  assign owner_req  = bus.req[cur_q];
  assign wr         = (state_q == BURST) && owner_req && !bus.full;
  assign last_hit   = bus.req_last[cur_q] || (beat_q == BEAT_W'(MAX_BURST - 1));
  assign next_ptr_d = (cur_q == CUR_W'(NUM_REQ - 1)) ? '0 : cur_q + 1'b1;

  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      cur_q       <= '0;
      rr_ptr_q    <= '0;
      beat_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            state_q <= BURST;
            gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_d;
            cur_q   <= pick_d;
            beat_q  <= '0;
          end
        end
        BURST: begin
          if (bus.full && owner_req && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
          // An owner dropping req abandons the burst; a write on the last beat completes it.
          if (!owner_req || (wr && last_hit)) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= next_ptr_d;
          end else if (wr) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.w_en      = wr;
  assign bus.data_in   = (state_q == BURST) ? bus.req_data[int'(cur_q)*data_width +: data_width]
                                            : '0;
  assign bus.ack       = wr ? gnt_q : '0;
  assign bus.gnt       = gnt_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a transaction-level model of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic w_clk = 1'b0;
  logic wrst_n;
  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter_if #(.data_width(DW), .NUM_REQ(N)) bus ();

  fifo_wr_arbiter #(.data_width(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .w_clk  (w_clk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [N-1:0] gnt;
    logic         wen;
    logic [15:0]  stall;
  } cyc_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [N-1:0]  ack;
  } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner = -1 means nobody holds the port.
  int owner = -1;
  int ptr   = 0;
  int beats = 0;
  int stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                            input logic [N-1:0] l, input logic f, input logic rn);
    cyc_t c;
    wr_t  w;
    logic [N-1:0] oh;
    bit   wrote;
    oh = '0;
    if (owner >= 0) oh[owner] = 1'b1;
    wrote   = (owner >= 0) && r[owner] && !f;
    c.gnt   = oh;
    c.wen   = wrote;
    c.stall = stall[15:0];
    cyc_q.push_back(c);
    if (wrote) begin
      w.data = d[owner*DW +: DW];
      w.ack  = oh;
      wr_q.push_back(w);
    end
    if (!rn) begin
      owner = -1; ptr = 0; beats = 0; stall = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (r[(ptr + k) % N]) begin
          owner = (ptr + k) % N;
          beats = 0;
          break;
        end
      end
    end else begin
      if (f && r[owner] && stall < 65535) stall++;
      if (!r[owner]) begin
        ptr = (owner + 1) % N; owner = -1;
      end else if (wrote) begin
        beats++;
        if (l[owner] || beats == MB) begin
          ptr = (owner + 1) % N; owner = -1;
        end
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                       input logic [N-1:0] l, input logic f, input logic rn);
    @(posedge w_clk);
    #1;
    bus.req      = r;
    bus.req_data = d;
    bus.req_last = l;
    bus.full     = f;
    wrst_n       = rn;
    model_step(r, d, l, f, rn);
  endtask

  // Monitor: one expected cycle record per clock, plus a write record whenever a write is due.
  initial begin
    cyc_t c;
    wr_t  w;
    forever begin
      @(negedge w_clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("gnt", 32'(bus.gnt), 32'(c.gnt));
        check("w_en", 32'(bus.w_en), 32'(c.wen));
        check("stall_cnt", 32'(bus.stall_cnt), 32'(c.stall));
        if (c.wen) begin
          w = wr_q.pop_front();
          check("data_in", 32'(bus.data_in), 32'(w.data));
          check("ack", 32'(bus.ack), 32'(w.ack));
        end else begin
          check("ack_idle", 32'(bus.ack), 32'd0);
        end
      end
    end
  end

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  initial begin
    logic [N-1:0]    r;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    int              fp;
    int              budget;

    wrst_n       = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.full     = 1'b0;

    drive('0, '0, '0, 1'b0, 1'b0);
    drive('0, '0, '0, 1'b0, 1'b1);
    @(negedge w_clk);
    #1;
    check("rst_data_in", 32'(bus.data_in), 32'd0);

    // Single requester, burst of 3 closed by req_last.
    for (int k = 0; k < 4; k++)
      drive(4'b0001, {24'h0, 8'hA0 + 8'(k)}, {3'b0, k == 3}, 1'b0, 1'b1);
    drive('0, '0, '0, 1'b0, 1'b1);

    // Everyone requesting, bursts end on the beat limit.
    for (int k = 0; k < 26; k++) drive(4'b1111, rand_data(), '0, 1'b0, 1'b1);
    drive('0, '0, '0, 1'b0, 1'b1);

    // Full for 5 cycles after the 2nd word.
    drive(4'b0001, rand_data(), '0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) drive(4'b0001, rand_data(), '0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) drive(4'b0001, rand_data(), '0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive(4'b0001, rand_data(), '0, 1'b0, 1'b1);
    drive('0, '0, '0, 1'b0, 1'b1);

    // Requester 1 abandons after 2 words while 0, 2 and 3 wait.
    for (int k = 0; k < 3; k++) drive(4'b0010, rand_data(), '0, 1'b0, 1'b1);
    for (int k = 0; k < 14; k++) drive(4'b1101, rand_data(), '0, 1'b0, 1'b1);
    drive('0, '0, '0, 1'b0, 1'b1);

    // Reset in the middle of owner 2's burst, then 0 and 2 competing.
    drive(4'b0100, rand_data(), '0, 1'b0, 1'b1);
    drive(4'b0100, rand_data(), '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) drive(4'b0101, rand_data(), '0, 1'b0, 1'b1);

    // Randomized traffic with varying back-pressure and occasional resets.
    r  = '0;
    fp = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) fp = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 30 : 80);
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 3) == 0);
      d = rand_data();
      drive(r, d, l, ($urandom_range(0, 99) < fp), ($urandom_range(0, 499) != 0));
    end
    drive('0, '0, '0, 1'b0, 1'b1);
    drive('0, '0, '0, 1'b0, 1'b0);

    // Long stall to push stall_cnt into saturation.
    drive(4'b0001, rand_data(), '0, 1'b0, 1'b1);
    for (int k = 0; k < 65540; k++) drive(4'b0001, {24'h0, 8'h5C}, '0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) drive(4'b0001, rand_data(), '0, 1'b0, 1'b1);
    drive('0, '0, '0, 1'b0, 1'b1);

    budget = 10;
    while (cyc_q.size() > 0 && budget > 0) begin
      @(negedge w_clk);
      budget--;
    end
    #2;
    check("cycles_drained", 32'(cyc_q.size()), 32'd0);
    check("writes_drained", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
